life_cell: RTL and testbench



---
 rtl/life_cell.sv | 65 ++++++
 tb/tb_life_cell.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/life_cell.sv
// Purpose: one Game of Life cell (B3/S23) with host write and previous-generation readback.
// Latency: 1 clock from enabled step or host write to alive / alive_prev.
// Backpressure: none; the cell freezes whenever neither write nor enb is asserted.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   n..nw               eight neighbour alive bits
//   write, val          host write strobe and the value it loads into alive
//   enb                 generation-step enable
//   alive, alive_prev   registered current state and state before the last step
module life_cell (
    input  logic clk,
    input  logic reset,
    input  logic n,
    input  logic ne,
    input  logic e,
    input  logic se,
    input  logic s,
    input  logic sw,
    input  logic w,
    input  logic nw,
    input  logic write,
    input  logic val,
    input  logic enb,
    output logic alive,
    output logic alive_prev
);

    logic       r_alive;
    logic       r_alive_prev;
    logic [3:0] w_count;
    logic       w_next;

    // Each neighbour bit is zero-extended so the sum is done at 4 bits (max 8).
    assign w_count = {3'b000, n}  + {3'b000, ne} + {3'b000, e}  + {3'b000, se}
                   + {3'b000, s}  + {3'b000, sw} + {3'b000, w}  + {3'b000, nw};

    // Three neighbours always yields a live cell; two preserves the current state.
    always_comb begin
        w_next = 1'b0;
        if (w_count == 4'd3) begin
            w_next = 1'b1;
        end else if (w_count == 4'd2) begin
            w_next = r_alive;
        end
    end

    // Reset beats write, write beats a generation step; a write leaves the
    // previous-generation value untouched so it still reflects the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alive      <= 1'b0;
            r_alive_prev <= 1'b0;
        end else if (write) begin
            r_alive      <= val;
        end else if (enb) begin
            r_alive_prev <= r_alive;
            r_alive      <= w_next;
        end
    end

    assign alive      = r_alive;
    assign alive_prev = r_alive_prev;

endmodule

// File: tb/tb_life_cell.sv
// Purpose: self-checking bench for life_cell, directed steps followed by random stimulus.
// Latency: expectations are checked 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives every input on every cycle.
module tb_life_cell;

    logic       clk;
    logic       reset;
    logic [7:0] nb;      // {nw, w, sw, s, se, e, ne, n}
    logic       write;
    logic       val;
    logic       enb;
    logic       alive;
    logic       alive_prev;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic m_alive;
    logic m_prev;

    life_cell dut (
        .clk        (clk),
        .reset      (reset),
        .n          (nb[0]),
        .ne         (nb[1]),
        .e          (nb[2]),
        .se         (nb[3]),
        .s          (nb[4]),
        .sw         (nb[5]),
        .w          (nb[6]),
        .nw         (nb[7]),
        .write      (write),
        .val        (val),
        .enb        (enb),
        .alive      (alive),
        .alive_prev (alive_prev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // B3/S23 written directly from the count of live neighbours.
    function automatic logic life_rule(input logic cur, input int live_cnt);
        if (live_cnt == 3) return 1'b1;
        if (live_cnt == 2) return cur;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance the reference using the inputs currently driven, clock the DUT,
    // then compare both outputs against the reference.
    task automatic cyc(input string tag);
        if (reset) begin
            m_alive = 1'b0;
            m_prev  = 1'b0;
        end else if (write) begin
            m_alive = val;
        end else if (enb) begin
            m_prev  = m_alive;
            m_alive = life_rule(m_alive, $countones(nb));
        end
        @(posedge clk);
        #1;
        check({tag, ".alive"}, alive, m_alive);
        check({tag, ".prev"},  alive_prev, m_prev);
    endtask

    task automatic set_in(input logic r, input logic [7:0] nbv, input logic wr,
                          input logic v, input logic en);
        reset = r;
        nb    = nbv;
        write = wr;
        val   = v;
        enb   = en;
    endtask

    initial begin
        m_alive = 1'bx;
        m_prev  = 1'bx;
        set_in(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset
        cyc("reset");
        check("reset_alive_const", alive, 1'b0);
        check("reset_prev_const", alive_prev, 1'b0);

        // Rules with enb=1
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc("cnt0");
        check("cnt0_const", alive, 1'b0);
        set_in(1'b0, 8'h15, 1'b0, 1'b0, 1'b1);         // n, e, s
        cyc("cnt3_birth");
        check("cnt3_birth_const", alive, 1'b1);
        set_in(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);         // n, e
        cyc("cnt2_survive");
        check("cnt2_survive_const", alive, 1'b1);
        set_in(1'b0, 8'h04, 1'b0, 1'b0, 1'b1);         // e
        cyc("cnt1_die");
        check("cnt1_die_const", alive, 1'b0);
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc("wr_for_cnt4");
        set_in(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        cyc("cnt4_die");
        check("cnt4_die_const", alive, 1'b0);
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc("wr_for_cnt8");
        set_in(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc("cnt8_die");
        check("cnt8_die_const", alive, 1'b0);
        set_in(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
        cyc("cnt2_dead");
        check("cnt2_dead_const", alive, 1'b0);

        // Write and freeze
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc("write1");
        check("write1_const", alive, 1'b1);
        set_in(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        cyc("frozen");
        check("frozen_const", alive, 1'b1);
        set_in(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc("still_life");
            check("still_life_const", alive, 1'b1);
        end
        set_in(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        cyc("lonely");
        check("lonely_const", alive, 1'b0);

        // alive_prev tracking
        set_in(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc("prev_reset");
        set_in(1'b0, 8'h15, 1'b0, 1'b0, 1'b0);
        cyc("prev_frozen");
        check("prev_frozen_const", alive, 1'b0);
        set_in(1'b0, 8'h15, 1'b0, 1'b0, 1'b1);
        cyc("prev_step1");
        check("prev_step1_alive_const", alive, 1'b1);
        check("prev_step1_prev_const", alive_prev, 1'b0);
        cyc("prev_step2");
        check("prev_step2_prev_const", alive_prev, 1'b1);

        // Priority: write over enb
        set_in(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc("pri_reset");
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc("pri_wr1");
        set_in(1'b0, 8'h15, 1'b1, 1'b0, 1'b1);
        cyc("pri_wr_vs_enb");
        check("pri_wr_alive_const", alive, 1'b0);
        check("pri_wr_prev_const", alive_prev, 1'b0);

        // Priority: reset over write
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc("pri_wr2");
        set_in(1'b0, 8'h15, 1'b0, 1'b0, 1'b1);
        cyc("pri_step");
        check("pri_step_prev_const", alive_prev, 1'b1);
        set_in(1'b1, 8'h15, 1'b1, 1'b1, 1'b1);
        cyc("pri_reset_vs_wr");
        check("pri_rst_alive_const", alive, 1'b0);
        check("pri_rst_prev_const", alive_prev, 1'b0);

        // Random stimulus against the reference
        for (int i = 0; i < 500; i++) begin
            set_in(($urandom_range(0, 99) < 3),
                   8'($urandom),
                   ($urandom_range(0, 99) < 12),
                   1'($urandom),
                   ($urandom_range(0, 99) < 70));
            // Bias neighbourhoods toward the interesting counts 2 and 3.
            if ($urandom_range(0, 1) == 1) begin
                nb = 8'h00;
                for (int k = 0; k < int'($urandom_range(2, 3)); k++) begin
                    nb[$urandom_range(0, 7)] = 1'b1;
                end
            end
            cyc("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
